ahb_lite_slave_mem: RTL and testbench
=====================================

# ahb_lite_slave_mem

AHB-lite subordinate (responder) backed by a word-organised register-file memory. It completes the transfers that the bench's manager-side interface drives: address-phase sampling, byte-lane writes, reads, optional wait-state insertion and the two-cycle ERROR response. It is the DUT-side counterpart used to close the loop on the AHB-lite verification environment.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 supported
- MEM_DEPTH, 256, number of 32-bit words
- WAIT_STATES, 0, data-phase stall cycles per transfer (0..15); effective only with AHB_SLAVE_WAIT_EN
- clk  input  1  bus clock, all state changes on rising edge
- HRESET  input  1  reset; asynchronous, active-high
- HSEL  input  1  slave select
- HADDR  input  ADDR_WIDTH  byte address
- HWRITE  input  1  1 = write, 0 = read
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HSIZE  input  3  0 = byte, 1 = half, 2 = word; >2 is illegal
- HBURST  input  3  accepted, not used for decoding
- HPROT  input  4  accepted, ignored
- HWDATA  input  DATA_WIDTH  write data, valid in data phase
- HREADY  input  1  bus ready (previous transfer complete)
- HREADYOUT  output  1  1 = data phase completes this cycle
- HRESP  output  1  0 = OKAY, 1 = ERROR
- HRDATA  output  DATA_WIDTH  read data

## Operation
- Transfer accepted on rising edge when HSEL & HREADY & HTRANS[1]; HADDR, HWRITE, HSIZE registered as the pending data phase.
- IDLE/BUSY, or HSEL=0: no access; next data phase is OKAY, zero wait.
- Error check at acceptance: word index HADDR[ADDR_WIDTH-1:2] >= MEM_DEPTH, HSIZE>2, half with HADDR[0]=1, word with HADDR[1:0]!=0 -> ERROR; memory never modified by an errored transfer.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. On legal accept with wait count 0, stays IDLE (data phase next cycle completes); with wait count >0 -> WAIT; on illegal accept -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0, down-counter decrements; at 1 -> IDLE (completing cycle).
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2. ERR2: HREADYOUT=1, HRESP=1 -> IDLE, or accepts next transfer like IDLE.
- Writes: committed on the edge ending the data phase (HREADYOUT=1); byte lanes little-endian from HADDR[1:0] and HSIZE; unselected lanes unchanged.
- Reads: HRDATA = mem[word index] (full word, all lanes) while in a read data phase, else 0.
- Write followed by read of same address back-to-back: read returns the new data.
- Memory is not reset; contents persist across HRESET.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, pending transfer cleared.
- HRESET asserted mid-operation: outputs take reset values immediately; pending write discarded.
- Zero-wait latency: accept at edge k, data phase completes at edge k+1, HRDATA valid in cycle k..k+1.
- With N wait states: HREADYOUT low exactly N cycles, completion at edge k+1+N.
- ERROR: always exactly two cycles (ERR1 then ERR2), independent of WAIT_STATES.
- Pipelining: next address phase overlaps the current data phase; acceptance gated by HREADY.

## Configuration
- AHB_SLAVE_WAIT_EN defined: wait-state counter and WAIT state compiled in; every legal NONSEQ/SEQ transfer stalls WAIT_STATES cycles.
- Not defined: counter and WAIT state removed; all legal transfers zero-wait regardless of WAIT_STATES.

## Test plan
- Assert HRESET for 3 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0 throughout.
- NONSEQ word write 0xDEADBEEF to 0x10, then NONSEQ read 0x10 back-to-back -> HRDATA=0xDEADBEEF, HRESP=0, no stall.
- Word 0x11223344 at 0x20, byte write 0xAA at 0x23 -> read 0x20 returns 0xAA223344.
- Halfword write to 0x01 -> ERR1 (HRESP=1, HREADYOUT=0) then ERR2 (HRESP=1, HREADYOUT=1); read 0x00 shows old contents.
- AHB_SLAVE_WAIT_EN, WAIT_STATES=2, read 0x10 -> HREADYOUT low exactly 2 cycles, then HRDATA=0xDEADBEEF.
- Same config, HRESET asserted during first wait cycle of write 0x55555555 to 0x30 -> HREADYOUT=1 immediately; later read 0x30 returns prior value.

Source files
------------

// File: rtl/ahb_lite_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_lite_slave_mem
//
// Purpose:
//   AHB-lite subordinate backed by a word-organised register-file memory.
//   Samples the address phase, performs byte-lane writes and full-word reads
//   in the following data phase, optionally stalls each legal transfer for a
//   fixed number of wait states, and answers illegal transfers with the
//   two-cycle ERROR response. Memory contents are not reset and persist
//   across HRESET.
//
// Configuration macro:
//   AHB_SLAVE_WAIT_EN - when defined, the wait-state counter and WAIT state
//                       are built in and every legal transfer stalls for
//                       WAIT_STATES cycles. When undefined, all legal
//                       transfers complete with zero wait states.
//
// Parameters:
//   ADDR_WIDTH  - HADDR width
//   DATA_WIDTH  - HWDATA/HRDATA width (only 32 is supported)
//   MEM_DEPTH   - number of 32-bit words
//   WAIT_STATES - data-phase stall cycles per transfer (0..15)
//
// Ports:
//   clk        in   bus clock, rising-edge active
//   HRESET     in   asynchronous active-high reset
//   HSEL       in   slave select
//   HADDR      in   byte address
//   HWRITE     in   1 = write, 0 = read
//   HTRANS     in   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   HSIZE      in   0 = byte, 1 = half, 2 = word; >2 illegal
//   HBURST     in   accepted, unused
//   HPROT      in   accepted, unused
//   HWDATA     in   write data, valid in data phase
//   HREADY     in   bus ready (previous transfer complete)
//   HREADYOUT  out  1 = data phase completes this cycle
//   HRESP      out  0 = OKAY, 1 = ERROR
//   HRDATA     out  read data (0 outside a read data phase)
// ---------------------------------------------------------------------------
module ahb_lite_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam logic [WIDX_W-1:0] DEPTH_LIMIT = WIDX_W'(MEM_DEPTH);

`ifdef AHB_SLAVE_WAIT_EN
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;
`endif

  state_t r_state;
  state_t w_nextState;

`ifdef AHB_SLAVE_WAIT_EN
  logic [3:0] r_waitCnt;
  logic [3:0] w_nextWaitCnt;
`endif

  // Pending data phase of the last legal accepted transfer
  logic             r_dpValid;
  logic             r_dpWrite;
  logic [IDX_W-1:0] r_dpIdx;
  logic [3:0]       r_dpByteEn;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic              w_accept;
  logic              w_phaseAdv;
  logic              w_commit;
  logic              w_outOfRange;
  logic              w_illegal;
  logic [3:0]        w_byteEn;
  logic [WIDX_W-1:0] w_wordIdxFull;
  logic              w_unused;

  // Address-phase decode
  assign w_accept      = HSEL & HREADY & HTRANS[1];
  assign w_wordIdxFull = HADDR[ADDR_WIDTH-1:2];
  assign w_outOfRange  = (w_wordIdxFull >= DEPTH_LIMIT);

  assign w_illegal = w_outOfRange
                   | (HSIZE > 3'd2)
                   | ((HSIZE == 3'd1) & HADDR[0])
                   | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  // Little-endian lane selection from the low address bits and size
  always_comb begin
    w_byteEn = 4'b0000;
    case (HSIZE)
      3'd0:    w_byteEn = 4'b0001 << HADDR[1:0];
      3'd1:    w_byteEn = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_byteEn = 4'b1111;
      default: w_byteEn = 4'b0000;
    endcase
  end

  // The bus moves on to the next data phase only when both the bus and this
  // slave are ready; a write lands on the edge that closes its data phase.
  assign w_phaseAdv = HREADY & HREADYOUT;
  assign w_commit   = r_dpValid & r_dpWrite & HREADYOUT;

  // Errored transfers never set r_dpValid, so they can neither write memory
  // nor drive read data.
  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      r_dpValid  <= 1'b0;
      r_dpWrite  <= 1'b0;
      r_dpIdx    <= '0;
      r_dpByteEn <= 4'b0000;
    end else if (w_phaseAdv) begin
      r_dpValid  <= w_accept & ~w_illegal;
      r_dpWrite  <= HWRITE;
      r_dpIdx    <= HADDR[IDX_W+1:2];
      r_dpByteEn <= w_byteEn;
    end
  end

  // Memory array deliberately has no reset so contents survive HRESET
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_dpByteEn[b]) begin
          r_mem[r_dpIdx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Read data is combinational from the array, so a read directly behind a
  // write to the same word sees the freshly committed value.
  assign HRDATA = (r_dpValid & ~r_dpWrite) ? r_mem[r_dpIdx] : '0;

  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= ST_IDLE;
`ifdef AHB_SLAVE_WAIT_EN
      r_waitCnt <= 4'd0;
`endif
    end else begin
      r_state   <= w_nextState;
`ifdef AHB_SLAVE_WAIT_EN
      r_waitCnt <= w_nextWaitCnt;
`endif
    end
  end

  // Next-state logic; ERR2 completes the error and behaves like IDLE for a
  // transfer presented alongside it.
  always_comb begin
    w_nextState = r_state;
`ifdef AHB_SLAVE_WAIT_EN
    w_nextWaitCnt = r_waitCnt;
`endif
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_nextState = ST_IDLE;
        if (w_accept) begin
          if (w_illegal) begin
            w_nextState = ST_ERR1;
          end
`ifdef AHB_SLAVE_WAIT_EN
          else if (WAIT_CNT != 4'd0) begin
            w_nextState   = ST_WAIT;
            w_nextWaitCnt = WAIT_CNT;
          end
`endif
        end
      end
`ifdef AHB_SLAVE_WAIT_EN
      ST_WAIT: begin
        w_nextWaitCnt = r_waitCnt - 4'd1;
        if (r_waitCnt <= 4'd1) begin
          w_nextState = ST_IDLE;
        end
      end
`endif
      ST_ERR1: begin
        w_nextState = ST_ERR2;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Response outputs depend on the state register only, which keeps the
  // HREADYOUT -> HREADY loop through the interconnect free of comb paths.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (r_state)
`ifdef AHB_SLAVE_WAIT_EN
      ST_WAIT: begin
        HREADYOUT = 1'b0;
      end
`endif
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
    endcase
  end

  // Inputs that are accepted but carry no meaning for this slave
`ifdef AHB_SLAVE_WAIT_EN
  assign w_unused = &{1'b0, HBURST, HPROT, HTRANS[0]};
`else
  assign w_unused = &{1'b0, HBURST, HPROT, HTRANS[0], 4'(WAIT_STATES)};
`endif

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_slave_mem
//
// Directed bench for ahb_lite_slave_mem. HREADY is looped back from
// HREADYOUT as in a single-slave system. The DUT is always built with
// WAIT_STATES=2; the expected stall count follows AHB_SLAVE_WAIT_EN.
// ---------------------------------------------------------------------------
module tb_ahb_lite_slave_mem;

`ifdef AHB_SLAVE_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic        clk    = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL   = 1'b0;
  logic [31:0] HADDR  = 32'h0;
  logic        HWRITE = 1'b0;
  logic [1:0]  HTRANS = 2'd0;
  logic [2:0]  HSIZE  = 3'd0;
  logic [2:0]  HBURST = 3'd0;
  logic [3:0]  HPROT  = 4'd0;
  logic [31:0] HWDATA = 32'h0;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  int checks = 0;
  int errors = 0;
  int stalls;

  ahb_lite_slave_mem #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .MEM_DEPTH   (256),
    .WAIT_STATES (2)
  ) dut (
    .clk       (clk),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  assign HREADY = HREADYOUT;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] trans,
                               input logic [31:0] addr, input logic wr,
                               input logic [2:0] size);
    HSEL   = sel;
    HTRANS = trans;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the completing cycle, counting stall cycles
  task automatic waitComplete(output int n);
    n = 0;
    @(negedge clk);
    while (!HREADYOUT && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic writeXfer(input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] data, input string tag);
    int n;
    applyStimulus(1'b1, 2'd2, addr, 1'b1, size);
    nextEdge();
    HWDATA = data;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 3'd0);
    waitComplete(n);
    checkOutput({tag, "_stall"}, 32'(n), 32'(WAITS));
    checkOutput({tag, "_resp"}, {31'h0, HRESP}, 32'h0);
    nextEdge();
  endtask

  task automatic readXfer(input logic [31:0] addr, input logic [31:0] expData,
                          input string tag);
    int n;
    applyStimulus(1'b1, 2'd2, addr, 1'b0, 3'd2);
    nextEdge();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 3'd0);
    waitComplete(n);
    checkOutput({tag, "_stall"}, 32'(n), 32'(WAITS));
    checkOutput({tag, "_data"}, HRDATA, expData);
    checkOutput({tag, "_resp"}, {31'h0, HRESP}, 32'h0);
    nextEdge();
  endtask

  // Illegal write, with a read of word 0 presented during the error so it
  // is accepted at the end of ERR2; word 0 must still hold oldWord0.
  task automatic errXfer(input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] data, input logic [31:0] oldWord0,
                         input string tag);
    int n;
    applyStimulus(1'b1, 2'd2, addr, 1'b1, size);
    nextEdge();
    HWDATA = data;
    applyStimulus(1'b1, 2'd2, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    checkOutput({tag, "_err1_ready"}, {31'h0, HREADYOUT}, 32'h0);
    checkOutput({tag, "_err1_resp"}, {31'h0, HRESP}, 32'h1);
    @(negedge clk);
    checkOutput({tag, "_err2_ready"}, {31'h0, HREADYOUT}, 32'h1);
    checkOutput({tag, "_err2_resp"}, {31'h0, HRESP}, 32'h1);
    nextEdge();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 3'd0);
    waitComplete(n);
    checkOutput({tag, "_rd0_stall"}, 32'(n), 32'(WAITS));
    checkOutput({tag, "_rd0_data"}, HRDATA, oldWord0);
    checkOutput({tag, "_rd0_resp"}, {31'h0, HRESP}, 32'h0);
    nextEdge();
  endtask

  initial begin
    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      checkOutput("rst_hresp", {31'h0, HRESP}, 32'h0);
      checkOutput("rst_hrdata", HRDATA, 32'h0);
    end
    @(posedge clk);
    #1;
    HRESET = 1'b0;

    // Back-to-back write then read of 0x10
    applyStimulus(1'b1, 2'd2, 32'h10, 1'b1, 3'd2);
    nextEdge();
    HWDATA = 32'hDEADBEEF;
    applyStimulus(1'b1, 2'd2, 32'h10, 1'b0, 3'd2);
    waitComplete(stalls);
    checkOutput("b2b_wr_stall", 32'(stalls), 32'(WAITS));
    checkOutput("b2b_wr_resp", {31'h0, HRESP}, 32'h0);
    nextEdge();
    HWDATA = 32'h0;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 3'd0);
    waitComplete(stalls);
    checkOutput("b2b_rd_stall", 32'(stalls), 32'(WAITS));
    checkOutput("b2b_rd_data", HRDATA, 32'hDEADBEEF);
    checkOutput("b2b_rd_resp", {31'h0, HRESP}, 32'h0);
    nextEdge();
    @(negedge clk);
    checkOutput("idle_hrdata", HRDATA, 32'h0);

    // Byte and halfword lanes; upper/lower junk in HWDATA must be ignored
    writeXfer(32'h20, 3'd2, 32'h11223344, "w20");
    writeXfer(32'h23, 3'd0, 32'hAA777777, "b23");
    readXfer (32'h20, 32'hAA223344, "r20a");
    writeXfer(32'h20, 3'd1, 32'hFFFF1234, "h20");
    readXfer (32'h20, 32'hAA221234, "r20b");
    writeXfer(32'h22, 3'd1, 32'h5678FFFF, "h22");
    readXfer (32'h20, 32'h56781234, "r20c");

    // Last legal word
    writeXfer(32'h3FC, 3'd2, 32'h600DF00D, "w3fc");
    readXfer (32'h3FC, 32'h600DF00D, "r3fc");

    // Error responses leave memory untouched
    writeXfer(32'h00, 3'd2, 32'hCAFEF00D, "w00");
    errXfer(32'h01, 3'd1, 32'hFFFFFFFF, 32'hCAFEF00D, "e_half01");
    errXfer(32'h400, 3'd2, 32'h12345678, 32'hCAFEF00D, "e_oob400");
    errXfer(32'h02, 3'd2, 32'h87654321, 32'hCAFEF00D, "e_word02");
    errXfer(32'h00, 3'd3, 32'h0BAD0BAD, 32'hCAFEF00D, "e_size3");

    // BUSY and deselected transfers do nothing
    applyStimulus(1'b1, 2'd1, 32'h00, 1'b1, 3'd2);
    nextEdge();
    HWDATA = 32'h11111111;
    applyStimulus(1'b0, 2'd2, 32'h00, 1'b1, 3'd2);
    @(negedge clk);
    checkOutput("busy_ready", {31'h0, HREADYOUT}, 32'h1);
    checkOutput("busy_resp", {31'h0, HRESP}, 32'h0);
    nextEdge();
    HWDATA = 32'h22222222;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("nosel_ready", {31'h0, HREADYOUT}, 32'h1);
    nextEdge();
    readXfer(32'h00, 32'hCAFEF00D, "r00_after_busy");

    // Reset during a write data phase discards the write
    writeXfer(32'h30, 3'd2, 32'h0BADCAFE, "w30");
    applyStimulus(1'b1, 2'd2, 32'h30, 1'b1, 3'd2);
    nextEdge();
    HWDATA = 32'h55555555;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("midrst_pre_ready", {31'h0, HREADYOUT}, (WAITS == 0) ? 32'h1 : 32'h0);
    #1;
    HRESET = 1'b1;
    #1;
    checkOutput("midrst_ready", {31'h0, HREADYOUT}, 32'h1);
    checkOutput("midrst_resp", {31'h0, HRESP}, 32'h0);
    checkOutput("midrst_rdata", HRDATA, 32'h0);
    @(posedge clk);
    #1;
    HRESET = 1'b0;
    HWDATA = 32'h0;
    readXfer(32'h30, 32'h0BADCAFE, "r30_after_rst");
    readXfer(32'h10, 32'hDEADBEEF, "r10_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
